// File: rtl/denorm16_pkg.sv
// ---------------------------------------------------------------------------
// denorm16_pkg
// Shared types and constants for the denorm16 right-shift (denormalising)
// unit: FSM state encoding, shift-count width and per-cycle step limit.
// ---------------------------------------------------------------------------
package denorm16_pkg;

  localparam int DATA_W   = 16;
  localparam int CNT_W    = 5;
  localparam int MAX_CNT  = 16;
  localparam int STEP_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/denorm16_if.sv
// ---------------------------------------------------------------------------
// denorm16_if
// Request/result handshake bundle for denorm16.
//   in_valid/in_ready  : request handshake (in_data, in_cnt, in_arith)
//   out_valid/out_ready: result handshake (out_data, out_sticky)
// Modports: master = requester/consumer side, slave = the shifter.
// ---------------------------------------------------------------------------
interface denorm16_if;
  import denorm16_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  in_cnt;
  logic              in_arith;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sticky;

  modport master (
    output in_valid, in_data, in_cnt, in_arith, out_ready,
    input  in_ready, out_valid, out_data, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_arith, out_ready,
    output in_ready, out_valid, out_data, out_sticky
  );
endinterface

// File: rtl/denorm16_step.sv
// ---------------------------------------------------------------------------
// denorm16_step
// Combinational 0..4-bit right shifter with a fill bit.
//   i_data        : word to shift
//   i_step        : shift amount, 0..4 (larger values pass data through)
//   i_fill        : bit inserted at the top
//   o_data        : shifted word
//   o_shifted_or  : OR of the bits shifted out (only with DENORM16_STICKY_EN)
// ---------------------------------------------------------------------------
module denorm16_step
  import denorm16_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_step,
  input  logic              i_fill,
`ifdef DENORM16_STICKY_EN
  output logic              o_shifted_or,
`endif
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_step)
      3'd1:    o_data = {{1{i_fill}}, i_data[DATA_W-1:1]};
      3'd2:    o_data = {{2{i_fill}}, i_data[DATA_W-1:2]};
      3'd3:    o_data = {{3{i_fill}}, i_data[DATA_W-1:3]};
      3'd4:    o_data = {{4{i_fill}}, i_data[DATA_W-1:4]};
      default: o_data = i_data;
    endcase
  end

`ifdef DENORM16_STICKY_EN
  always_comb begin
    o_shifted_or = 1'b0;
    case (i_step)
      3'd1:    o_shifted_or = i_data[0];
      3'd2:    o_shifted_or = |i_data[1:0];
      3'd3:    o_shifted_or = |i_data[2:0];
      3'd4:    o_shifted_or = |i_data[3:0];
      default: o_shifted_or = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/denorm16.sv
// ---------------------------------------------------------------------------
// denorm16
// Multi-cycle 16-bit right shifter (inverse of the leading-zero counter).
// Shifts in_data right by min(in_cnt,16), at most 4 bits per cycle, filling
// with zeros or with in_data[15] (in_arith). Optional sticky = OR of all
// bits shifted out.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous reset, active low
//   bus    : denorm16_if.slave (request and result handshakes)
// Build option: define DENORM16_STICKY_EN to build the sticky logic;
// otherwise out_sticky is tied to 0 and data/timing are unchanged.
// ---------------------------------------------------------------------------
module denorm16
  import denorm16_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  denorm16_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;
  logic [DATA_W-1:0]  r_data;
  logic [CNT_W-1:0]   r_rem;
  logic               r_fill;
  logic [CNT_W-1:0]   w_cnt_sat;
  logic [2:0]         w_step;
  logic [DATA_W-1:0]  w_step_data;
  logic               w_accept;

  assign w_cnt_sat = (bus.in_cnt > CNT_W'(MAX_CNT)) ? CNT_W'(MAX_CNT) : bus.in_cnt;
  assign w_step    = (r_rem > CNT_W'(STEP_MAX)) ? 3'(STEP_MAX) : r_rem[2:0];
  assign w_accept  = (r_state == IDLE) && bus.in_valid;

`ifdef DENORM16_STICKY_EN
  logic w_step_or;
  logic r_sticky;
`endif

  denorm16_step u_step (
    .i_data       (r_data),
    .i_step       (w_step),
    .i_fill       (r_fill),
`ifdef DENORM16_STICKY_EN
    .o_shifted_or (w_step_or),
`endif
    .o_data       (w_step_data)
  );

  // ---- control: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // SHIFT lasts until the remaining count fits in one step.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = (w_cnt_sat != '0) ? SHIFT : DONE;
      SHIFT:   if (r_rem <= CNT_W'(STEP_MAX)) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ---- datapath: capture on accept, then step per SHIFT cycle ----
  // The fill bit is frozen at capture so intermediate data never changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_rem  <= '0;
      r_fill <= 1'b0;
    end else if (w_accept) begin
      r_data <= bus.in_data;
      r_rem  <= w_cnt_sat;
      r_fill <= bus.in_arith & bus.in_data[DATA_W-1];
    end else if (r_state == SHIFT) begin
      r_data <= w_step_data;
      r_rem  <= r_rem - {2'b00, w_step};
    end
  end

`ifdef DENORM16_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_sticky <= 1'b0;
    else if (w_accept)          r_sticky <= 1'b0;
    else if (r_state == SHIFT)  r_sticky <= r_sticky | w_step_or;
  end
  assign bus.out_sticky = r_sticky;
`else
  assign bus.out_sticky = 1'b0;
`endif

  // ---- outputs: registered data, handshakes decoded from state ----
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_data;

endmodule

// File: tb/tb_denorm16.sv
module tb_denorm16;
  import denorm16_pkg::*;

`ifdef DENORM16_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  denorm16_if bus();

  denorm16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  // Reference: arithmetic shift of a sign/zero-extended 32-bit value.
  function automatic void model(input logic [15:0] d, input logic [4:0] c, input logic a,
                                output logic [15:0] od, output logic os, output int lat);
    int          sat;
    logic        fill;
    logic [31:0] ext;
    sat  = (c > 5'd16) ? 16 : int'(c);
    fill = a & d[15];
    ext  = fill ? {16'hFFFF, d} : {16'h0000, d};
    od   = 16'(ext >> sat);
    os   = STICKY_EN && ((32'(d) & ((32'd1 << sat) - 32'd1)) != 32'd0);
    lat  = 1 + (sat + 3) / 4;
  endfunction

  typedef struct {
    logic [15:0] data;
    logic [4:0]  cnt;
    logic        arith;
    logic [15:0] exp_data;
    logic        exp_sticky;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  // One request; returns result seen after 'hold' extra DONE cycles.
  task automatic run_req(input string tag, input logic [15:0] d, input logic [4:0] c,
                         input logic a, input int hold,
                         output logic [15:0] rd, output logic rs, output int lat);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cnt   = c;
    bus.in_arith = a;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    bus.in_cnt   = 5'($urandom);
    bus.in_arith = 1'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check({tag, "_valid_held"}, 32'(bus.out_valid), 32'd1);
    rd = bus.out_data;
    rs = bus.out_sticky;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_released"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] rd, ed;
    logic        rs, es;
    int          lat, el;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cnt    = '0;
    bus.in_arith  = 1'b0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{16'hF0F0, 5'd4,  1'b0, 16'h0F0F, 1'b0, 2};
    vecs[1]  = '{16'h8001, 5'd1,  1'b1, 16'hC000, 1'b1, 2};
    vecs[2]  = '{16'h1234, 5'd0,  1'b0, 16'h1234, 1'b0, 1};
    vecs[3]  = '{16'h8000, 5'd31, 1'b1, 16'hFFFF, 1'b1, 5};
    vecs[4]  = '{16'hF000, 5'd8,  1'b0, 16'h00F0, 1'b0, 3};
    vecs[5]  = '{16'h8000, 5'd16, 1'b0, 16'h0000, 1'b1, 5};
    vecs[6]  = '{16'h7FFF, 5'd15, 1'b1, 16'h0000, 1'b1, 5};
    vecs[7]  = '{16'h8421, 5'd5,  1'b1, 16'hFC21, 1'b1, 3};
    vecs[8]  = '{16'hABCD, 5'd17, 1'b0, 16'h0000, 1'b1, 5};
    vecs[9]  = '{16'h0010, 5'd4,  1'b1, 16'h0001, 1'b0, 2};
    vecs[10] = '{16'hFFFF, 5'd12, 1'b1, 16'hFFFF, 1'b1, 4};
    vecs[11] = '{16'h00FF, 5'd3,  1'b0, 16'h001F, 1'b1, 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_data",   32'(bus.out_data),   32'd0);
    check("rst_out_sticky", 32'(bus.out_sticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].data, vecs[i].cnt, vecs[i].arith, i % 3, rd, rs, lat);
      check($sformatf("vec%0d_data", i),   32'(rd),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d_sticky", i), 32'(rs),  32'(vecs[i].exp_sticky & STICKY_EN));
      check($sformatf("vec%0d_lat", i),    32'(lat), 32'(vecs[i].exp_lat));
    end

    // Back-pressure with ignored requests while DONE
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'hF000; bus.in_cnt = 5'd8; bus.in_arith = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 16'h5555; bus.in_cnt = 5'd0; bus.in_arith = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_data", k),  32'(bus.out_data),  32'h00F0);
      check($sformatf("bp_hold%0d_ready", k), 32'(bus.in_ready),  32'd0);
      check($sformatf("bp_hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_idle_ready", 32'(bus.in_ready),  32'd1);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    check("bp_idle_data",  32'(bus.out_data),  32'h00F0);
    @(posedge clk); #1;
    check("bp_no_accept",  32'(bus.out_valid), 32'd0);

    // Reset in the middle of SHIFT
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 16'hABCD; bus.in_cnt = 5'd13; bus.in_arith = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_shift_valid", 32'(bus.out_valid), 32'd0);
    check("mid_shift_ready", 32'(bus.in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid",  32'(bus.out_valid),  32'd0);
    check("abort_data",   32'(bus.out_data),   32'd0);
    check("abort_sticky", 32'(bus.out_sticky), 32'd0);
    check("abort_ready",  32'(bus.in_ready),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_req("post_rst", 16'hABCD, 5'd13, 1'b0, 0, rd, rs, lat);
    check("post_rst_data",   32'(rd),  32'h0005);
    check("post_rst_sticky", 32'(rs),  32'(STICKY_EN));
    check("post_rst_lat",    32'(lat), 32'd5);

    // Randomized against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [15:0] d;
      logic [4:0]  c;
      logic        a;
      d = 16'($urandom);
      c = 5'($urandom_range(0, 31));
      a = 1'($urandom);
      model(d, c, a, ed, es, el);
      run_req($sformatf("rnd%0d", n), d, c, a, int'($urandom_range(0, 2)), rd, rs, lat);
      check($sformatf("rnd%0d_data", n),   32'(rd),  32'(ed));
      check($sformatf("rnd%0d_sticky", n), 32'(rs),  32'(es));
      check($sformatf("rnd%0d_lat", n),    32'(lat), 32'(el));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
